// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq
// Description : Sequential 32-bit shifter. A start request captures the
//               operand, shift amount and shift type, then five barrel stages
//               (distances 16, 8, 4, 2, 1) are applied on successive clock
//               edges, so latency does not depend on the shift amount. The
//               result is registered and flagged with a one-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_shift,
    input  logic        op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic [31:0] data_out,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] C_LAST_STAGE = 3'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_stage;
    logic [31:0] r_work;
    logic [4:0]  r_shamt;
    logic        r_op;
    logic [31:0] r_data_out;

    logic        w_start;
    logic        w_last;
    logic [4:0]  w_dist;
    logic        w_en;
    logic [31:0] w_stage_val;

    // A start is accepted only outside SHIFT; the final stage is stage 4.
    assign w_start = (r_state != S_SHIFT) && ctrl_shift;
    assign w_last  = (r_state == S_SHIFT) && (r_stage == C_LAST_STAGE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: requests during SHIFT are ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_next = ctrl_shift ? S_SHIFT : S_IDLE;
            end
            S_SHIFT: begin
                w_state_next = (r_stage == C_LAST_STAGE) ? S_DONE : S_SHIFT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Stage selection: counter 0..4 picks distance 16..1 gated by shamt bit 4..0.
    always_comb begin
        w_dist = 5'd0;
        w_en   = 1'b0;
        case (r_stage)
            3'd0: begin w_dist = 5'd16; w_en = r_shamt[4]; end
            3'd1: begin w_dist = 5'd8;  w_en = r_shamt[3]; end
            3'd2: begin w_dist = 5'd4;  w_en = r_shamt[2]; end
            3'd3: begin w_dist = 5'd2;  w_en = r_shamt[1]; end
            3'd4: begin w_dist = 5'd1;  w_en = r_shamt[0]; end
            default: begin w_dist = 5'd0; w_en = 1'b0; end
        endcase
    end

    // One barrel stage: sll fills with zeros, sra replicates bit 31.
    always_comb begin
        w_stage_val = r_work;
        if (w_en) begin
            if (r_op) begin
                w_stage_val = $unsigned($signed(r_work) >>> w_dist);
            end else begin
                w_stage_val = r_work << w_dist;
            end
        end
    end

    // Operand capture, stage counter and working register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage <= 3'd0;
            r_work  <= 32'd0;
            r_shamt <= 5'd0;
            r_op    <= 1'b0;
        end else if (w_start) begin
            r_stage <= 3'd0;
            r_work  <= data_in;
            r_shamt <= shamt;
            r_op    <= op;
        end else if (r_state == S_SHIFT) begin
            r_work <= w_stage_val;
            if (!w_last) begin
                r_stage <= r_stage + 3'd1;
            end
        end
    end

    // Result register: updates only on the SHIFT->DONE transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= 32'd0;
        end else if (w_last) begin
            r_data_out <= w_stage_val;
        end
    end

    assign data_out       = r_data_out;
    assign data_resultRDY = (r_state == S_DONE);
    assign busy           = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq
// Description : Directed self-checking bench for shift_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_shift;
    logic        op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        data_resultRDY;
    logic        busy;

    int checks;
    int failures;
    int cyc;
    logic [31:0] last_result;

    shift_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .op             (op),
        .data_in        (data_in),
        .shamt          (shamt),
        .data_out       (data_out),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full operation; returns in the DONE cycle if chain=1, else one cycle later.
    task automatic run_op(input logic o, input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] exp, input string nm, input bit chain,
                          output int pulse_cyc);
        ctrl_shift = 1'b1; op = o; data_in = d; shamt = s;
        step();
        ctrl_shift = 1'b0; data_in = 32'hDEADBEEF; shamt = 5'd7; op = ~o;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1 || data_resultRDY !== 1'b0 || data_out !== last_result) begin
                failures++;
                $display("FAIL %s busy_window[%0d]: busy=%b rdy=%b out=%h required busy=1 rdy=0 out=%h",
                         nm, i, busy, data_resultRDY, data_out, last_result);
            end
            step();
        end
        pulse_cyc = cyc;
        checks++;
        if (data_resultRDY !== 1'b1 || busy !== 1'b0 || data_out !== exp) begin
            failures++;
            $display("FAIL %s done: rdy=%b busy=%b out=%h required rdy=1 busy=0 out=%h",
                     nm, data_resultRDY, busy, data_out, exp);
        end
        last_result = exp;
        if (!chain) begin
            step();
            checks++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_out !== exp) begin
                failures++;
                $display("FAIL %s idle_after: rdy=%b busy=%b out=%h required rdy=0 busy=0 out=%h",
                         nm, data_resultRDY, busy, data_out, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_shift = 1'b1; op = 1'b0; data_in = 32'hFFFFFFFF; shamt = 5'd3;
        step();
        step();
        reset = 1'b0; ctrl_shift = 1'b0;
        checks++;
        if (data_out !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL reset: out=%h busy=%b rdy=%b required out=0 busy=0 rdy=0",
                     data_out, busy, data_resultRDY);
        end
        last_result = 32'h0;
    endtask

    task automatic test_sra_basic();
        int pc;
        run_op(1'b1, 32'h80000000, 5'd4,  32'hF8000000, "sra_80000000_4",  1'b0, pc);
        run_op(1'b1, 32'h80000000, 5'd21, 32'hFFFFFC00, "sra_80000000_21", 1'b0, pc);
    endtask

    task automatic test_extremes();
        int pc;
        run_op(1'b0, 32'h00000001, 5'd31, 32'h80000000, "sll_1_31",       1'b0, pc);
        run_op(1'b1, 32'h7FFFFFFF, 5'd31, 32'h00000000, "sra_7fffffff_31", 1'b0, pc);
        run_op(1'b0, 32'h12345678, 5'd13, 32'h8ACF0000, "sll_12345678_13", 1'b0, pc);
    endtask

    task automatic test_shamt_zero();
        int pc;
        run_op(1'b0, 32'h12345678, 5'd0, 32'h12345678, "sll_shamt0", 1'b0, pc);
    endtask

    task automatic test_ignore_during_shift();
        int pulses;
        ctrl_shift = 1'b1; op = 1'b0; data_in = 32'h0000000F; shamt = 5'd8;
        step();                         // edge k
        ctrl_shift = 1'b0;
        step();                         // edge k+1
        ctrl_shift = 1'b1; op = 1'b1; data_in = 32'hFFFFFFFF; shamt = 5'd1;
        step();                         // edge k+2: must be ignored
        ctrl_shift = 1'b0;
        checks++;
        if (busy !== 1'b1 || data_out !== last_result) begin
            failures++;
            $display("FAIL ignore_midshift: busy=%b out=%h required busy=1 out=%h",
                     busy, data_out, last_result);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (data_resultRDY === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || data_out !== 32'h00000F00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: pulses=%0d out=%h busy=%b required pulses=1 out=00000f00 busy=0",
                     pulses, data_out, busy);
        end
        last_result = 32'h00000F00;
    endtask

    task automatic test_reset_abort();
        int pulses;
        int pc;
        ctrl_shift = 1'b1; op = 1'b1; data_in = 32'hF0000000; shamt = 5'd2;
        step();                         // edge k
        ctrl_shift = 1'b0;
        step();                         // k+1
        step();                         // k+2
        reset = 1'b1;
        step();                         // k+3: reset
        reset = 1'b0;
        checks++;
        if (data_out !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: out=%h busy=%b rdy=%b required out=0 busy=0 rdy=0",
                     data_out, busy, data_resultRDY);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (data_resultRDY === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_pulse: active_cycles=%0d required 0", pulses);
        end
        last_result = 32'h0;
        run_op(1'b1, 32'hF0000000, 5'd2, 32'hFC000000, "sra_after_abort", 1'b0, pc);
    endtask

    task automatic test_back_to_back();
        int p1;
        int p2;
        run_op(1'b0, 32'h00000005, 5'd2, 32'h00000014, "b2b_first",  1'b1, p1);
        run_op(1'b0, 32'h00000003, 5'd1, 32'h00000006, "b2b_second", 1'b0, p2);
        checks++;
        if (p2 - p1 != 6) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles required 6", p2 - p1);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; last_result = 32'h0;
        reset = 1'b1; ctrl_shift = 1'b0; op = 1'b0; data_in = 32'h0; shamt = 5'd0;
        #1;
        test_reset();
        test_sra_basic();
        test_extremes();
        test_shamt_zero();
        test_ignore_during_shift();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ctrl_shift  input  1  start request; sampled on the rising edge of clock.
REQ-005 op  input  1  shift type, sampled with ctrl_shift: 0 = logical left (sll), 1 = arithmetic right (sra).
REQ-006 data_in  input  32  operand, sampled with ctrl_shift.
REQ-007 shamt  input  5  shift amount 0..31, sampled with ctrl_shift.
REQ-008 data_out  output  32  registered result; holds the last completed result.
REQ-009 data_resultRDY  output  1  one-cycle pulse: data_out valid for the operation just completed.
REQ-010 busy  output  1  high while an operation is in progress (SHIFT state).

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE or DONE, ctrl_shift=1 at an edge SHALL capture data_in, shamt and op into internal registers, clear the stage counter to 0, and enter SHIFT.
REQ-013 In IDLE or DONE, ctrl_shift=0 at an edge SHALL enter or remain in IDLE.
REQ-014 In SHIFT, each edge SHALL apply one barrel stage to the working register: counter 0..4 selects distance 16, 8, 4, 2, 1 respectively, gated by captured shamt bit 4, 3, 2, 1, 0 respectively; a cleared bit passes the value unchanged.
REQ-015 Each sll stage SHALL shift toward the MSB and fill vacated LSBs with 0.
REQ-016 Each sra stage SHALL shift toward the LSB and fill vacated MSBs with a copy of bit 31 of the working register.
REQ-017 Latency SHALL be fixed regardless of shamt: start captured at edge k, stages applied at edges k+1..k+5, DONE entered at edge k+5.
REQ-018 At edge k+5 data_out SHALL load the final working value; data_resultRDY SHALL be 1 only while in DONE (exactly one cycle).
REQ-019 busy SHALL be 1 exactly while in SHIFT (edges k+1..k+5 inclusive of cycle after k); 0 in IDLE and DONE.
REQ-020 ctrl_shift asserted while in SHIFT SHALL be ignored; captured operands SHALL not change until the next accepted start.
REQ-021 ctrl_shift asserted in the DONE cycle SHALL start a new operation back-to-back (no idle cycle required).
REQ-022 data_out SHALL change only at reset or at SHIFT->DONE; it SHALL hold its value in IDLE and during a following operation.
REQ-023 shamt=0 SHALL return data_in unchanged after the full fixed latency.

Reset
REQ-024 reset=1 at an edge SHALL force state IDLE, stage counter 0, working and captured registers 0, data_out=0x00000000, data_resultRDY=0, busy=0.
REQ-025 reset SHALL take priority over ctrl_shift and over any in-progress operation; an aborted operation SHALL produce no data_resultRDY pulse.

Verification
REQ-026 sra, data_in=0x80000000, shamt=4 -> data_resultRDY high cycle after edge k+5, data_out=0xF8000000, busy high for 5 cycles.
REQ-027 sll, data_in=0x00000001, shamt=31 -> data_out=0x80000000; then sra 0x7FFFFFFF by 31 -> data_out=0x00000000.
REQ-028 sll, data_in=0x12345678, shamt=0 -> data_out=0x12345678 after same 5-cycle busy window.
REQ-029 Start sll 0x0000000F by 8, assert ctrl_shift with data_in=0xFFFFFFFF at edge k+2 -> ignored; data_out=0x00000F00, single data_resultRDY pulse.
REQ-030 Start sra 0xF0000000 by 2, assert reset at edge k+3 -> data_out=0x00000000, busy=0, no data_resultRDY; subsequent sra 0xF0000000 by 2 -> 0xFC000000.
REQ-031 ctrl_shift held during DONE cycle with sll 0x00000003 by 1 after a first op -> first result pulse, then second pulse 6 cycles later with data_out=0x00000006.
